// File: rtl/vga_pkg.sv
// Shared raster phase type and default 640x480@60 timing constants.
// Used by vga_axis_counter and vga_timing_gen.
package vga_pkg;

  typedef enum logic [1:0] {
    SYNC,
    BACK,
    ACTIVE,
    FRONT
  } phase_t;

  localparam int DIV_DEF         = 4;
  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 783;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 514;

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle from the timing generator to the pixel path.
// The generator drives it through master; consumers read it through slave.
interface vga_if;

  logic        pixTick;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic        lineStart;
  logic        frameStart;
  logic [15:0] frameCount;

  modport master (
    output pixTick, hCount, vCount,
    output bright, hSync, vSync,
    output lineStart, frameStart,
    output frameCount
  );

  modport slave (
    input pixTick, hCount, vCount,
    input bright, hSync, vSync,
    input lineStart, frameStart,
    input frameCount
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping count, sync/back/active/front phase FSM.
// phase_nxt is exported so the top can register outputs with no skew.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL     = H_TOTAL_DEF,
  parameter int SYNC_LEN  = H_SYNC_DEF,
  parameter int ACT_START = H_ACT_START_DEF,
  parameter int ACT_END   = H_ACT_END_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] count,
  output phase_t     phase_nxt,
  output logic       wrap
);

  localparam logic [9:0] LAST   = 10'(TOTAL - 1);
  localparam logic [9:0] SYNC_E = 10'(SYNC_LEN);
  localparam logic [9:0] ACT_S  = 10'(ACT_START);
  localparam logic [9:0] ACT_E  = 10'(ACT_END + 1);

  logic [9:0] count_nxt;
  phase_t     phase;

  assign wrap = en && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = (count == LAST) ? 10'd0
                                  : count + 10'd1;
    end
  end

  // Phase boundaries are keyed on the count being entered.
  always_comb begin
    phase_nxt = phase;
    if (en) begin
      unique case (phase)
        SYNC:    if (count_nxt == SYNC_E) phase_nxt = BACK;
        BACK:    if (count_nxt == ACT_S)  phase_nxt = ACTIVE;
        ACTIVE:  if (count_nxt == ACT_E)  phase_nxt = FRONT;
        FRONT:   if (wrap)                phase_nxt = SYNC;
        default: phase_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      phase <= SYNC;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with internal pixel-rate divider.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic clk,
  input  logic rst,
  vga_if.master vga
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          adv;
  logic          h_wrap;
  logic          v_wrap;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  phase_t        h_ph;
  phase_t        v_ph;

  logic pix_q, ls_q, fs_q;
  logic hs_q, vs_q, br_q;

  assign adv = (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_LEN  (H_SYNC),
    .ACT_START (H_ACT_START),
    .ACT_END   (H_ACT_END)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .count     (h_cnt),
    .phase_nxt (h_ph),
    .wrap      (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_LEN  (V_SYNC),
    .ACT_START (V_ACT_START),
    .ACT_END   (V_ACT_END)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .en        (h_wrap),
    .count     (v_cnt),
    .phase_nxt (v_ph),
    .wrap      (v_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pix_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      div_cnt <= adv ? '0 : div_cnt + 1'b1;
      pix_q   <= adv;
      ls_q    <= h_wrap;
      fs_q    <= v_wrap;
      hs_q    <= (h_ph != SYNC);
      vs_q    <= (v_ph != SYNC);
      br_q    <= (h_ph == ACTIVE) && (v_ph == ACTIVE);
    end
  end

  assign vga.pixTick    = pix_q;
  assign vga.lineStart  = ls_q;
  assign vga.frameStart = fs_q;
  assign vga.hSync      = hs_q;
  assign vga.vSync      = vs_q;
  assign vga.bright     = br_q;
  assign vga.hCount     = h_cnt;
  assign vga.vCount     = v_cnt;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (v_wrap) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign vga.frameCount = frame_q;
`else
  assign vga.frameCount = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks, reduced
// instance (DIV=2, 20x10 raster) for frame, wrap and mid-frame reset.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vga_if d_if ();
  vga_if s_if ();

  vga_timing_gen u_d (
    .clk (clk),
    .rst (rst),
    .vga (d_if)
  );

  vga_timing_gen #(
    .DIV         (2),
    .H_TOTAL     (20),
    .H_SYNC      (3),
    .H_ACT_START (5),
    .H_ACT_END   (16),
    .V_TOTAL     (10),
    .V_SYNC      (2),
    .V_ACT_START (3),
    .V_ACT_END   (8)
  ) u_s (
    .clk (clk),
    .rst (rst),
    .vga (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d_tick1, d_hs1, d_hs1_h, d_ls1, d_ls2, d_ls_n, d_ls_v;
  int s_tick1, s_tick1_h;
  int s_br1, s_br1_h, s_br1_v, s_brl, s_brl_h, s_brl_v;
  int s_fs1, s_fs1_ls, s_fs1_pt, s_fs1_h, s_fs1_v;
  int s_fs_n, s_ls_n;
  int d_cnt_bad, s_cnt_bad, s_der_bad, stray, consec;
  int d_pt_prev, s_pt_prev;
  int h, v, n;
  logic found;

  initial begin
    checks = 0; errors = 0;
    d_tick1 = -1; d_hs1 = -1; d_hs1_h = -1;
    d_ls1 = -1; d_ls2 = -1; d_ls_n = 0; d_ls_v = -1;
    s_tick1 = -1; s_tick1_h = -1;
    s_br1 = -1; s_br1_h = -1; s_br1_v = -1;
    s_brl = -1; s_brl_h = -1; s_brl_v = -1;
    s_fs1 = -1; s_fs1_ls = -1; s_fs1_pt = -1;
    s_fs1_h = -1; s_fs1_v = -1;
    s_fs_n = 0; s_ls_n = 0;
    d_cnt_bad = 0; s_cnt_bad = 0; s_der_bad = 0;
    stray = 0; consec = 0;
    d_pt_prev = 0; s_pt_prev = 0;

    rst = 1'b1;
    repeat (5) tick();
    chk("rst_d_h", d_if.hCount, 0);
    chk("rst_d_v", d_if.vCount, 0);
    chk("rst_d_pt", d_if.pixTick, 0);
    chk("rst_d_hs", d_if.hSync, 0);
    chk("rst_d_vs", d_if.vSync, 0);
    chk("rst_d_br", d_if.bright, 0);
    chk("rst_d_ls", d_if.lineStart, 0);
    chk("rst_d_fs", d_if.frameStart, 0);
    chk("rst_d_fc", d_if.frameCount, 0);
    chk("rst_s_h", s_if.hCount, 0);
    chk("rst_s_vs", s_if.vSync, 0);
    rst = 1'b0;

    for (int c = 1; c <= 6500; c++) begin
      tick();
      if (d_if.hCount != (c / 4) % 800) d_cnt_bad++;
      if (d_if.vCount != (c / 3200) % 525) d_cnt_bad++;
      if (d_if.pixTick && d_tick1 < 0) d_tick1 = c;
      if (d_if.hSync && d_hs1 < 0) begin
        d_hs1 = c; d_hs1_h = d_if.hCount;
      end
      if (d_if.lineStart) begin
        d_ls_n++;
        if (d_ls1 < 0) begin
          d_ls1 = c; d_ls_v = d_if.vCount;
        end else if (d_ls2 < 0) d_ls2 = c;
      end
      if ((d_if.lineStart || d_if.frameStart) && !d_if.pixTick) stray++;
      if (d_if.pixTick && d_pt_prev != 0) consec++;
      d_pt_prev = d_if.pixTick;
      if (c <= 1210) begin
        h = s_if.hCount; v = s_if.vCount;
        if (h != (c / 2) % 20) s_cnt_bad++;
        if (v != (c / 40) % 10) s_cnt_bad++;
        if (s_if.hSync != (h >= 3)) s_der_bad++;
        if (s_if.vSync != (v >= 2)) s_der_bad++;
        if (s_if.bright != (h >= 5 && h <= 16 && v >= 3 && v <= 8))
          s_der_bad++;
        if (s_if.pixTick && s_tick1 < 0) begin
          s_tick1 = c; s_tick1_h = h;
        end
        if (s_if.bright && s_br1 < 0) begin
          s_br1 = c; s_br1_h = h; s_br1_v = v;
        end
        if (s_if.bright && c < 400) begin
          s_brl = c; s_brl_h = h; s_brl_v = v;
        end
        if (s_if.lineStart) s_ls_n++;
        if (s_if.frameStart) begin
          s_fs_n++;
          if (s_fs1 < 0) begin
            s_fs1 = c; s_fs1_ls = s_if.lineStart;
            s_fs1_pt = s_if.pixTick; s_fs1_h = h; s_fs1_v = v;
          end
        end
        if ((s_if.lineStart || s_if.frameStart) && !s_if.pixTick) stray++;
        if (s_if.pixTick && s_pt_prev != 0) consec++;
        s_pt_prev = s_if.pixTick;
        if (c == 1210) begin
`ifdef VGA_FRAME_COUNT_EN
          chk("s_fcount3", s_if.frameCount, 3);
`else
          chk("s_fcount0", s_if.frameCount, 0);
`endif
        end
      end
    end

    chk("d_first_tick", d_tick1, 4);
    chk("d_hs_rise_c", d_hs1, 384);
    chk("d_hs_rise_h", d_hs1_h, 96);
    chk("d_ls1", d_ls1, 3200);
    chk("d_ls_period", d_ls2 - d_ls1, 3200);
    chk("d_ls_count", d_ls_n, 2);
    chk("d_ls_vcount", d_ls_v, 1);
    chk("d_counts", d_cnt_bad, 0);
    chk("d_fcount", d_if.frameCount, 0);
    chk("s_first_tick", s_tick1, 2);
    chk("s_first_tick_h", s_tick1_h, 1);
    chk("s_br_first_c", s_br1, 130);
    chk("s_br_first_h", s_br1_h, 5);
    chk("s_br_first_v", s_br1_v, 3);
    chk("s_br_last_c", s_brl, 353);
    chk("s_br_last_h", s_brl_h, 16);
    chk("s_br_last_v", s_brl_v, 8);
    chk("s_fs_first", s_fs1, 400);
    chk("s_fs_ls", s_fs1_ls, 1);
    chk("s_fs_pt", s_fs1_pt, 1);
    chk("s_fs_h", s_fs1_h, 0);
    chk("s_fs_v", s_fs1_v, 0);
    chk("s_fs_count", s_fs_n, 3);
    chk("s_ls_count", s_ls_n, 30);
    chk("s_counts", s_cnt_bad, 0);
    chk("s_derived", s_der_bad, 0);
    chk("pt_consec", consec, 0);
    chk("stray_pulse", stray, 0);

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (s_if.hCount == 10 && s_if.vCount == 5 && !s_if.pixTick)
        found = 1'b1;
      else
        tick();
    end
    chk("mid_found", int'(found), 1);
    rst = 1'b1;
    tick();
    chk("mid_s_h", s_if.hCount, 0);
    chk("mid_s_v", s_if.vCount, 0);
    chk("mid_s_hs", s_if.hSync, 0);
    chk("mid_s_br", s_if.bright, 0);
    chk("mid_s_pt", s_if.pixTick, 0);
    chk("mid_d_h", d_if.hCount, 0);
    stray = 0;
    repeat (2) begin
      tick();
      if (s_if.pixTick || s_if.lineStart || s_if.frameStart) stray++;
      if (d_if.pixTick || d_if.lineStart || d_if.frameStart) stray++;
    end
    chk("mid_no_pulse", stray, 0);
    rst = 1'b0;
    n = -1;
    for (int c = 1; c <= 10 && n < 0; c++) begin
      tick();
      if (s_if.pixTick) n = c;
    end
    chk("mid_restart_c", n, 2);
    chk("mid_restart_h", s_if.hCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
